// File: rtl/axis_fifo_sc_if.sv
// rtl/axis_fifo_sc_if.sv - AXI4-Stream bundle for axis_fifo_sc
//
// Purpose : groups one AXI4-Stream channel (payload, sideband, handshake).
// Signals : tdata[DWIDTH], tid[TID_WIDTH], tdest[TDEST_WIDTH], tuser[TUSER_WIDTH],
//           tlast, tvalid (master -> slave), tready (slave -> master).
// Modports: master drives payload/tvalid, slave drives tready.
interface axis_fifo_sc_if #(
  parameter int DWIDTH      = 8,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 8
) ();
  logic [DWIDTH-1:0]      tdata;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tid, tdest, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tid, tdest, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_fifo_sc.sv
// rtl/axis_fifo_sc.sv - single-clock FWFT AXI4-Stream FIFO
//
// Purpose : same-domain stream buffer, DEPTH = 2**AWIDTH words including the
//           output register. tdata plus enabled tid/tdest/tuser/tlast are packed
//           LSB-first into one storage word; disabled fields take no bits and
//           read back as 0.
// Ports   : aclk, aresetn (async assert, active low)
//           s_axis       - slave stream (write side), tready = not full
//           m_axis       - master stream (read side), first-word-fall-through
//           data_count   - words held, 0..DEPTH
//           almost_full  - data_count >= DEPTH-AF_MARGIN
//           almost_empty - data_count <= AE_MARGIN
// Option  : define AXIS_FIFO_PACKET_MODE_EN for store-and-forward (needs TLAST=1).
module axis_fifo_sc #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 4,
  parameter int USE_TID     = 0,
  parameter int TID_WIDTH   = 8,
  parameter int USE_TDEST   = 0,
  parameter int TDEST_WIDTH = 8,
  parameter int USE_TUSER   = 0,
  parameter int TUSER_WIDTH = 8,
  parameter int TLAST       = 1,
  parameter int AF_MARGIN   = 2,
  parameter int AE_MARGIN   = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_fifo_sc_if.slave     s_axis,
  axis_fifo_sc_if.master    m_axis,
  output logic [AWIDTH:0]   data_count,
  output logic              almost_full,
  output logic              almost_empty
);
  localparam int DEPTH    = 1 << AWIDTH;
  localparam int ID_W     = (USE_TID   != 0) ? TID_WIDTH   : 0;
  localparam int DEST_W   = (USE_TDEST != 0) ? TDEST_WIDTH : 0;
  localparam int USER_W   = (USE_TUSER != 0) ? TUSER_WIDTH : 0;
  localparam int LAST_W   = (TLAST     != 0) ? 1 : 0;
  localparam int OFF_ID   = DWIDTH;
  localparam int OFF_DEST = OFF_ID + ID_W;
  localparam int OFF_USER = OFF_DEST + DEST_W;
  localparam int OFF_LAST = OFF_USER + USER_W;
  localparam int WW       = OFF_LAST + LAST_W;

  localparam logic [AWIDTH:0]   FULL_LVL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_LVL   = (AWIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [AWIDTH:0]   AE_LVL   = (AWIDTH+1)'(AE_MARGIN);
  localparam logic [AWIDTH:0]   CNT_ONE  = 1;
  localparam logic [AWIDTH-1:0] PTR_ONE  = 1;

  logic [WW-1:0]     mem [DEPTH];
  logic [WW-1:0]     s_word;
  logic [WW-1:0]     out_q;
  logic              out_valid_q;
  logic              ready_q;
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   count_q, count_d, mem_count;
  logic              s_fire, m_fire, m_valid, m_last;
  logic              mem_has, out_free, load_mem, bypass, write_mem;

  // Pack / unpack the storage word.
  assign s_word[DWIDTH-1:0] = s_axis.tdata;
  assign m_axis.tdata       = out_q[DWIDTH-1:0];

  if (USE_TID != 0) begin : g_tid
    assign s_word[OFF_ID +: TID_WIDTH] = s_axis.tid;
    assign m_axis.tid = out_q[OFF_ID +: TID_WIDTH];
  end else begin : g_no_tid
    logic unused_tid;
    assign unused_tid = ^s_axis.tid;
    assign m_axis.tid = '0;
  end

  if (USE_TDEST != 0) begin : g_tdest
    assign s_word[OFF_DEST +: TDEST_WIDTH] = s_axis.tdest;
    assign m_axis.tdest = out_q[OFF_DEST +: TDEST_WIDTH];
  end else begin : g_no_tdest
    logic unused_tdest;
    assign unused_tdest = ^s_axis.tdest;
    assign m_axis.tdest = '0;
  end

  if (USE_TUSER != 0) begin : g_tuser
    assign s_word[OFF_USER +: TUSER_WIDTH] = s_axis.tuser;
    assign m_axis.tuser = out_q[OFF_USER +: TUSER_WIDTH];
  end else begin : g_no_tuser
    logic unused_tuser;
    assign unused_tuser = ^s_axis.tuser;
    assign m_axis.tuser = '0;
  end

  if (TLAST != 0) begin : g_tlast
    assign s_word[OFF_LAST] = s_axis.tlast;
    assign m_last = out_q[OFF_LAST];
  end else begin : g_no_tlast
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign m_last = 1'b0;
  end

  assign m_axis.tlast  = m_last;
  assign m_axis.tvalid = m_valid;
  assign s_axis.tready = ready_q;

  assign s_fire = s_axis.tvalid && ready_q;
  assign m_fire = m_valid && m_axis.tready;

  // count_q includes the output register; mem_count is what still sits in RAM.
  assign mem_count = count_q - {{AWIDTH{1'b0}}, out_valid_q};
  assign mem_has   = (mem_count != '0);
  assign out_free  = !out_valid_q || m_fire;
  assign load_mem  = out_free && mem_has;
  // Refill the draining output register straight from the write port so a
  // one-deep stream keeps 1 beat/cycle. An empty FIFO never takes this path.
  assign bypass    = out_valid_q && m_fire && !mem_has && s_fire;
  assign write_mem = s_fire && !bypass;

  always_comb begin
    count_d = count_q;
    if (s_fire && !m_fire)      count_d = count_q + CNT_ONE;
    else if (!s_fire && m_fire) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge aclk) begin
    if (write_mem) mem[wr_ptr_q] <= s_word;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != FULL_LVL);
      if (write_mem) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (load_mem) begin
        out_q       <= mem[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        out_valid_q <= 1'b1;
      end else if (bypass) begin
        out_q       <= s_word;
        out_valid_q <= 1'b1;
      end else if (m_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [AWIDTH:0] pkt_count_q;
  logic            stream_q;
  logic            pkt_in, pkt_out;

  if (TLAST == 0) begin : g_cfg_err
    $error("axis_fifo_sc: packet mode needs TLAST = 1");
  end

  assign pkt_in  = s_fire && s_axis.tlast;
  assign pkt_out = m_fire && m_last;
  // Full overrides the wait so an oversize packet streams; stream_q keeps a
  // started packet flowing until its tlast leaves.
  assign m_valid = out_valid_q &&
                   ((pkt_count_q != '0) || (count_q == FULL_LVL) || stream_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_q <= '0;
      stream_q    <= 1'b0;
    end else begin
      if (pkt_in && !pkt_out)      pkt_count_q <= pkt_count_q + CNT_ONE;
      else if (!pkt_in && pkt_out) pkt_count_q <= pkt_count_q - CNT_ONE;
      if (m_fire) stream_q <= !m_last;
    end
  end
`else
  assign m_valid = out_valid_q;
`endif

  assign data_count   = count_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
endmodule

// File: tb/tb_axis_fifo_sc.sv
// tb/tb_axis_fifo_sc.sv - self-checking bench for axis_fifo_sc
module tb_axis_fifo_sc;
  localparam int DW = 8, AW = 4, TIDW = 4, TDW = 8, TUW = 3, DEPTH = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_fifo_sc_if #(.DWIDTH(DW), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TUSER_WIDTH(TUW)) s_if ();
  axis_fifo_sc_if #(.DWIDTH(DW), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TUSER_WIDTH(TUW)) m_if ();
  logic [AW:0] data_count;
  logic        almost_full, almost_empty;

  axis_fifo_sc #(
    .DWIDTH(DW), .AWIDTH(AW), .USE_TID(1), .TID_WIDTH(TIDW), .USE_TDEST(0),
    .TDEST_WIDTH(TDW), .USE_TUSER(1), .TUSER_WIDTH(TUW), .TLAST(1),
    .AF_MARGIN(2), .AE_MARGIN(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
    .data_count(data_count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_rx  = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are decided by signals stable between edges, so the
  // negedge sees exactly what the next posedge will transfer.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_if.tvalid && s_if.tready)
        sb_q.push_back({s_if.tlast, s_if.tuser, s_if.tid, s_if.tdata});
      if (m_if.tvalid && m_if.tready) begin
        n_rx++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got beat 0x%0h expected no beat",
                   {m_if.tlast, m_if.tuser, m_if.tid, m_if.tdata});
        end else begin
          logic [15:0] exp_beat;
          exp_beat = sb_q.pop_front();
          check("sb_beat", 32'({m_if.tlast, m_if.tuser, m_if.tid, m_if.tdata}), 32'(exp_beat));
          check("sb_tdest", 32'(m_if.tdest), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] d, input logic [3:0] id,
                           input logic [2:0] u, input logic l);
    logic ok;
    ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tid    = id;
    s_if.tuser  = u;
    s_if.tlast  = l;
    for (int k = 0; k < 200; k++) begin
      ok = s_if.tready;
      @(posedge aclk); #1;
      if (ok) break;
    end
    s_if.tvalid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    m_if.tready = 1'b1;
    while (data_count != 0 && k < 300) begin
      @(posedge aclk); #1;
      k++;
    end
    check("drain_count", 32'(data_count), 32'd0);
    check("drain_sb", 32'(sb_q.size()), 32'd0);
    m_if.tready = 1'b0;
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    sb_q.delete();
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  typedef struct {
    logic [7:0] tdata;
    logic [3:0] tid;
    logic [2:0] tuser;
    logic       tlast;
    logic [4:0] exp_count;
    logic       exp_af;
    logic       exp_ae;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[DEPTH];
  int   rx0, sent;
  logic w, r;
  logic [4:0] c0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].tdata     = 8'(8'h30 + i * 7);
      tbl[i].tid       = 4'(15 - i);
      tbl[i].tuser     = 3'(i);
      tbl[i].tlast     = (i % 4 == 3);
      tbl[i].exp_count = 5'(i + 1);
      tbl[i].exp_af    = ((i + 1) >= DEPTH - 2);
      tbl[i].exp_ae    = ((i + 1) <= 1);
      tbl[i].exp_ready = ((i + 1) < DEPTH);
    end

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tid = '0; s_if.tuser = '0;
    s_if.tlast = 1'b0;  s_if.tdest = 8'hFF;
    m_if.tready = 1'b0;

    // Reset state.
    repeat (3) @(posedge aclk); #1;
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tready", 32'(s_if.tready), 32'd0);
    check("rst_count",  32'(data_count),  32'd0);
    check("rst_ae",     32'(almost_empty), 32'd1);
    check("rst_af",     32'(almost_full),  32'd0);
    check("rst_tdata",  32'(m_if.tdata),   32'd0);
    check("rst_tlast",  32'(m_if.tlast),   32'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rel_tready", 32'(s_if.tready), 32'd1);

    // Single write: visible one edge after acceptance.
    send_beat(8'hA5, 4'h3, 3'h5, 1'b1);
    check("t1_count",   32'(data_count),  32'd1);
    check("t1_tvalid0", 32'(m_if.tvalid), 32'd0);
    @(posedge aclk); #1;
    check("t1_tvalid1", 32'(m_if.tvalid), 32'd1);
    check("t1_tdata",   32'(m_if.tdata),  32'hA5);
    check("t1_count1",  32'(data_count),  32'd1);
    check("t1_ae",      32'(almost_empty), 32'd1);
    drain();

    // Fill to capacity from the table, checking flags per vector.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(tbl[i].tdata, tbl[i].tid, tbl[i].tuser, tbl[i].tlast);
      check("t2_count", 32'(data_count),   32'(tbl[i].exp_count));
      check("t2_af",    32'(almost_full),  32'(tbl[i].exp_af));
      check("t2_ae",    32'(almost_empty), 32'(tbl[i].exp_ae));
      check("t2_ready", 32'(s_if.tready),  32'(tbl[i].exp_ready));
    end
    s_if.tvalid = 1'b1; s_if.tdata = 8'hEE; s_if.tlast = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
      check("t2_hold_ready", 32'(s_if.tready), 32'd0);
      check("t2_hold_count", 32'(data_count),  32'd16);
      check("t2_head_valid", 32'(m_if.tvalid), 32'd1);
      check("t2_head_data",  32'(m_if.tdata),  32'(tbl[0].tdata));
    end
    s_if.tvalid = 1'b0;
    rx0 = n_rx;
    m_if.tready = 1'b1;
    @(posedge aclk); #1;
    check("t2_free_count", 32'(data_count),  32'd15);
    check("t2_free_ready", 32'(s_if.tready), 32'd1);
    drain();
    check("t2_rx", 32'(n_rx - rx0), 32'd16);

    // Random valid/ready stream.
    do_reset();
    rx0 = n_rx;
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      if (!s_if.tvalid && ($urandom_range(1, 0) == 1)) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'($urandom);
        s_if.tid    = 4'($urandom);
        s_if.tuser  = 3'($urandom);
        s_if.tlast  = (sent == 999) || ($urandom_range(3, 0) == 0);
      end
      m_if.tready = ($urandom_range(1, 0) == 1);
      w  = s_if.tvalid && s_if.tready;
      r  = m_if.tvalid && m_if.tready;
      c0 = data_count;
      @(posedge aclk); #1;
      if (w && r) check("t3_count_same", 32'(data_count), 32'(c0));
      else        check("t3_count_step", 32'(data_count), 32'(int'(c0) + int'(w) - int'(r)));
      if (w) begin
        sent++;
        s_if.tvalid = 1'b0;
      end
    end
    s_if.tvalid = 1'b0;
    check("t3_sent", 32'(sent), 32'd1000);
    drain();
    check("t3_rx", 32'(n_rx - rx0), 32'd1000);

    // Asynchronous reset mid-read.
    do_reset();
    for (int i = 0; i < 5; i++)
      send_beat(8'(8'h60 + i), 4'(i), 3'(i), (i == 4));
    @(posedge aclk); #1;
    check("t5_count", 32'(data_count), 32'd5);
    m_if.tready = 1'b1;
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check("t5_async_tvalid", 32'(m_if.tvalid), 32'd0);
    check("t5_async_count",  32'(data_count),  32'd0);
    check("t5_async_tready", 32'(s_if.tready), 32'd0);
    sb_q.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (5) begin
      @(posedge aclk); #1;
      check("t5_no_stale", 32'(m_if.tvalid), 32'd0);
      check("t5_zero_cnt", 32'(data_count),  32'd0);
    end
    rx0 = n_rx;
    send_beat(8'h5A, 4'hC, 3'h2, 1'b1);
    drain();
    check("t5_rx", 32'(n_rx - rx0), 32'd1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: hold until tlast, then stream an oversize packet.
    do_reset();
    rx0 = n_rx;
    m_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h10 + i), 4'(i), 3'(i), 1'b0);
    repeat (3) begin
      @(posedge aclk); #1;
      check("t6_hold", 32'(m_if.tvalid), 32'd0);
    end
    send_beat(8'h13, 4'h3, 3'h3, 1'b1);
    check("t6_release", 32'(m_if.tvalid), 32'd1);
    drain();
    check("t6_rx4", 32'(n_rx - rx0), 32'd4);
    rx0 = n_rx;
    for (int i = 0; i < 16; i++) send_beat(8'(8'h80 + i), 4'(i), 3'(i), 1'b0);
    check("t6_full_count", 32'(data_count),  32'd16);
    check("t6_override",   32'(m_if.tvalid), 32'd1);
    m_if.tready = 1'b1;
    for (int i = 16; i < 20; i++) send_beat(8'(8'h80 + i), 4'(i), 3'(i), (i == 19));
    drain();
    check("t6_rx20", 32'(n_rx - rx0), 32'd20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
